// File: rtl/pipe_pkg.sv
// Shared pipeline definitions.
// Holds the datapath widths, the reset PC, the NOP encoding and the layout of
// the IF/ID register. The ID/EX and EX/MEM registers reuse the same layout.
package pipe_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0]  RESET_PC  = 32'h0040_0000;
  // sll $0,$0,0
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc4;
    logic               valid;
  } ifid_t;

  // Bubble contents: a NOP that is marked invalid.
  function automatic ifid_t make_bubble(input logic [INSTR_W-1:0] nop);
    ifid_t b;
    b.instr = nop;
    b.pc4   = '0;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// Pipeline register with hold and flush controls.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (loads a bubble)
//   i_flush    : load a bubble at the next edge (wins over i_hold)
//   i_hold     : keep the current contents
//   i_d        : data loaded when neither flush nor hold is active
//   o_q        : register contents
module ifid_reg
  import pipe_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_flush,
  input  logic  i_hold,
  input  ifid_t i_d,
  output ifid_t o_q
);

  ifid_t r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= make_bubble(NOP_INSTR);
    end else if (i_flush) begin
      // A flush squashes even a held instruction: it is on the wrong path.
      r_q <= make_bubble(NOP_INSTR);
    end else if (!i_hold) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_redirect_unit.sv
// IF stage: PC register, next-PC selection and the IF/ID register.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   stall                 : hold PC and IF/ID
//   br_sel, br_target     : taken branch from EX (highest priority)
//   jump_f, jump_target   : jump decoded in ID (only honoured when IF/ID is valid)
//   imem_addr/imem_rdata  : combinational instruction memory port (addr = PC)
//   ifid_instr/pc4/valid  : IF/ID register contents
//   flush_idex            : clear ID/EX at the next edge (= br_sel)
//   align_err             : sticky flag, a redirect target had addr[1:0] != 0
//   taken_cnt             : saturating count of redirects (branch + jump)
module fetch_redirect_unit
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = pipe_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = pipe_pkg::NOP_INSTR,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             br_sel,
  input  logic [31:0]      br_target,
  input  logic             jump_f,
  input  logic [31:0]      jump_target,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      ifid_instr,
  output logic [31:0]      ifid_pc4,
  output logic             ifid_valid,
  output logic             flush_idex,
  output logic             align_err,
  output logic [CNT_W-1:0] taken_cnt
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic [ADDR_W-1:0] w_pc4;
  logic [ADDR_W-1:0] w_target;
  logic              w_jump_take;
  logic              w_redirect;
  logic              r_align_err;
  logic [CNT_W-1:0]  r_taken_cnt;
  ifid_t             w_ifid_d;
  ifid_t             w_ifid_q;

  assign w_pc4 = r_pc + 32'd4;  // modulo 2^32, wraps silently

  // A jump is only real if its instruction in IF/ID is valid; a stall
  // re-presents it next cycle, so it must not fire while stalled.
  assign w_jump_take = jump_f && w_ifid_q.valid && !stall;
  assign w_redirect  = br_sel || w_jump_take;
  assign w_target    = br_sel ? br_target : jump_target;

  always_comb begin
    w_pc_next = w_pc4;
    if (br_sel) begin
      w_pc_next = {br_target[ADDR_W-1:2], 2'b00};
    end else if (stall) begin
      w_pc_next = r_pc;
    end else if (w_jump_take) begin
      w_pc_next = {jump_target[ADDR_W-1:2], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_align_err <= 1'b0;
      r_taken_cnt <= '0;
    end else begin
      r_pc <= w_pc_next;
      if (w_redirect && (w_target[1:0] != 2'b00)) begin
        r_align_err <= 1'b1;
      end
      if (w_redirect && (r_taken_cnt != {CNT_W{1'b1}})) begin
        r_taken_cnt <= r_taken_cnt + 1'b1;
      end
    end
  end

  assign w_ifid_d.instr = imem_rdata;
  assign w_ifid_d.pc4   = w_pc4;
  assign w_ifid_d.valid = 1'b1;

  ifid_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_redirect),
    .i_hold  (stall),
    .i_d     (w_ifid_d),
    .o_q     (w_ifid_q)
  );

  assign imem_addr  = r_pc;
  assign ifid_instr = w_ifid_q.instr;
  assign ifid_pc4   = w_ifid_q.pc4;
  assign ifid_valid = w_ifid_q.valid;
  assign flush_idex = br_sel;
  assign align_err  = r_align_err;
  assign taken_cnt  = r_taken_cnt;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit. The driver applies one cycle of
// inputs just after each rising edge and queues the outputs expected during
// that cycle; the monitor pops and compares on the falling edge.
// Instruction memory model: RESET_PC returns 0x2008_0001, any other
// address returns addr ^ 0xA000_0000.
module tb_fetch_redirect_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic        br_sel = 1'b0;
  logic [31:0] br_target = '0;
  logic        jump_f = 1'b0;
  logic [31:0] jump_target = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        flush_idex;
  logic        align_err;
  logic [15:0] taken_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    string       nm;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        flush;
    logic        align;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  assign imem_rdata = (imem_addr == 32'h0040_0000) ? 32'h2008_0001
                                                   : (imem_addr ^ 32'hA000_0000);

  fetch_redirect_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .br_sel      (br_sel),
    .br_target   (br_target),
    .jump_f      (jump_f),
    .jump_target (jump_target),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .ifid_instr  (ifid_instr),
    .ifid_pc4    (ifid_pc4),
    .ifid_valid  (ifid_valid),
    .flush_idex  (flush_idex),
    .align_err   (align_err),
    .taken_cnt   (taken_cnt)
  );

  task automatic chk(input string nm, input string fld,
                     input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
  endtask

  // Monitor: compare whenever an expectation is pending.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      $display("txn %-14s addr=%h instr=%h pc4=%h v=%0b fl=%0b al=%0b cnt=%h",
               e.nm, imem_addr, ifid_instr, ifid_pc4, ifid_valid, flush_idex,
               align_err, taken_cnt);
      chk(e.nm, "imem_addr",  imem_addr,           e.addr);
      chk(e.nm, "ifid_instr", ifid_instr,          e.instr);
      chk(e.nm, "ifid_pc4",   ifid_pc4,            e.pc4);
      chk(e.nm, "ifid_valid", {31'd0, ifid_valid}, {31'd0, e.valid});
      chk(e.nm, "flush_idex", {31'd0, flush_idex}, {31'd0, e.flush});
      chk(e.nm, "align_err",  {31'd0, align_err},  {31'd0, e.align});
      chk(e.nm, "taken_cnt",  {16'd0, taken_cnt},  {16'd0, e.cnt});
    end
  end

  task automatic drive(input logic rst, input logic st, input logic br,
                       input logic [31:0] bt, input logic jf, input logic [31:0] jt);
    @(posedge clk);
    #1;
    rst_n       = rst;
    stall       = st;
    br_sel      = br;
    br_target   = bt;
    jump_f      = jf;
    jump_target = jt;
  endtask

  task automatic cyc(input string nm, input logic rst, input logic st,
                     input logic br, input logic [31:0] bt,
                     input logic jf, input logic [31:0] jt,
                     input logic [31:0] e_addr, input logic [31:0] e_instr,
                     input logic [31:0] e_pc4, input logic e_valid,
                     input logic e_flush, input logic e_align,
                     input logic [15:0] e_cnt);
    exp_t e;
    drive(rst, st, br, bt, jf, jt);
    e.nm = nm; e.addr = e_addr; e.instr = e_instr; e.pc4 = e_pc4;
    e.valid = e_valid; e.flush = e_flush; e.align = e_align; e.cnt = e_cnt;
    exp_q.push_back(e);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    //  name          rst st br bt            jf jt            addr          instr         pc4           v  fl al cnt
    // T1 reset and sequential fetch
    cyc("reset",       0, 0, 0, 32'h0,        0, 32'h0,        32'h0040_0000, 32'h0,        32'h0,        0, 0, 0, 16'd0);
    cyc("rst_release", 1, 0, 0, 32'h0,        0, 32'h0,        32'h0040_0000, 32'h0,        32'h0,        0, 0, 0, 16'd0);
    cyc("fetch1",      1, 0, 0, 32'h0,        0, 32'h0,        32'h0040_0004, 32'h2008_0001, 32'h0040_0004, 1, 0, 0, 16'd0);
    cyc("fetch2",      1, 0, 0, 32'h0,        0, 32'h0,        32'h0040_0008, 32'hA040_0004, 32'h0040_0008, 1, 0, 0, 16'd0);
    cyc("fetch3",      1, 0, 0, 32'h0,        0, 32'h0,        32'h0040_000C, 32'hA040_0008, 32'h0040_000C, 1, 0, 0, 16'd0);
    // T2 branch at pc 0x0040_0010
    cyc("branch",      1, 0, 1, 32'h0040_0100, 0, 32'h0,       32'h0040_0010, 32'hA040_000C, 32'h0040_0010, 1, 1, 0, 16'd0);
    cyc("br_bubble",   1, 0, 0, 32'h0,        0, 32'h0,        32'h0040_0100, 32'h0,        32'h0,        0, 0, 0, 16'd1);
    cyc("br_target",   1, 0, 0, 32'h0,        0, 32'h0,        32'h0040_0104, 32'hA040_0100, 32'h0040_0104, 1, 0, 0, 16'd1);
    // T3 stall for 3 cycles (jump ignored), then branch during stall
    cyc("stall1",      1, 1, 0, 32'h0,        0, 32'h0,        32'h0040_0108, 32'hA040_0104, 32'h0040_0108, 1, 0, 0, 16'd1);
    cyc("stall2_jmp",  1, 1, 0, 32'h0,        1, 32'h0040_0200, 32'h0040_0108, 32'hA040_0104, 32'h0040_0108, 1, 0, 0, 16'd1);
    cyc("stall3",      1, 1, 0, 32'h0,        0, 32'h0,        32'h0040_0108, 32'hA040_0104, 32'h0040_0108, 1, 0, 0, 16'd1);
    cyc("stall_br",    1, 1, 1, 32'h0040_0300, 0, 32'h0,       32'h0040_0108, 32'hA040_0104, 32'h0040_0108, 1, 1, 0, 16'd1);
    cyc("stbr_bubble", 1, 0, 0, 32'h0,        0, 32'h0,        32'h0040_0300, 32'h0,        32'h0,        0, 0, 0, 16'd2);
    // T4 jump, jump with invalid IF/ID, jump under stall
    cyc("jump",        1, 0, 0, 32'h0,        1, 32'h0040_0200, 32'h0040_0304, 32'hA040_0300, 32'h0040_0304, 1, 0, 0, 16'd2);
    cyc("jmp_invalid", 1, 0, 0, 32'h0,        1, 32'h0040_0500, 32'h0040_0200, 32'h0,        32'h0,        0, 0, 0, 16'd3);
    cyc("jmp_stall",   1, 1, 0, 32'h0,        1, 32'h0040_0600, 32'h0040_0204, 32'hA040_0200, 32'h0040_0204, 1, 0, 0, 16'd3);
    cyc("after_jstl",  1, 0, 0, 32'h0,        0, 32'h0,        32'h0040_0204, 32'hA040_0200, 32'h0040_0204, 1, 0, 0, 16'd3);
    // T5 branch+jump conflict, misaligned branch target
    cyc("br_and_jmp",  1, 0, 1, 32'h0040_0700, 1, 32'h0040_0800, 32'h0040_0208, 32'hA040_0204, 32'h0040_0208, 1, 1, 0, 16'd3);
    cyc("br_misalign", 1, 0, 1, 32'h0040_0103, 0, 32'h0,       32'h0040_0700, 32'h0,        32'h0,        0, 1, 0, 16'd4);
    cyc("aligned_pc",  1, 0, 0, 32'h0,        0, 32'h0,        32'h0040_0100, 32'h0,        32'h0,        0, 0, 1, 16'd5);
    cyc("align_stick", 1, 0, 0, 32'h0,        0, 32'h0,        32'h0040_0104, 32'hA040_0100, 32'h0040_0104, 1, 0, 1, 16'd5);
    // T6 PC wrap
    cyc("br_top",      1, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,       32'h0040_0108, 32'hA040_0104, 32'h0040_0108, 1, 1, 1, 16'd5);
    cyc("pc_top",      1, 0, 0, 32'h0,        0, 32'h0,        32'hFFFF_FFFC, 32'h0,        32'h0,        0, 0, 1, 16'd6);
    cyc("pc_wrap",     1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 32'h5FFF_FFFC, 32'h0000_0000, 1, 0, 1, 16'd6);
    cyc("pc_wrap2",    1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0004, 32'hA000_0000, 32'h0000_0004, 1, 0, 1, 16'd6);
    // Reset asserted in the middle of a redirect
    cyc("rst_mid_br",  0, 0, 1, 32'h0040_0900, 0, 32'h0,       32'h0040_0000, 32'h0,        32'h0,        0, 1, 0, 16'd0);
    cyc("rst_rel2",    1, 0, 0, 32'h0,        0, 32'h0,        32'h0040_0000, 32'h0,        32'h0,        0, 0, 0, 16'd0);
    cyc("refetch",     1, 0, 0, 32'h0,        0, 32'h0,        32'h0040_0004, 32'h2008_0001, 32'h0040_0004, 1, 0, 0, 16'd0);
    // Counter saturation: 65534 + 1 + 4 = 2^16 + 3 redirects
    for (int i = 0; i < 65534; i++) drive(1, 0, 1, 32'h0040_0000, 0, 32'h0);
    cyc("cnt_fffe",    1, 0, 1, 32'h0040_0000, 0, 32'h0,       32'h0040_0000, 32'h0,        32'h0,        0, 1, 0, 16'hFFFE);
    for (int i = 0; i < 4; i++) drive(1, 0, 1, 32'h0040_0000, 0, 32'h0);
    cyc("cnt_sat",     1, 0, 0, 32'h0,        0, 32'h0,        32'h0040_0000, 32'h0,        32'h0,        0, 0, 0, 16'hFFFF);
    cyc("cnt_hold",    1, 0, 0, 32'h0,        0, 32'h0,        32'h0040_0004, 32'h2008_0001, 32'h0040_0004, 1, 0, 0, 16'hFFFF);

    @(negedge clk);
    #1;
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
